// File: rtl/md_pkg.sv
// Shared op codes and FSM encoding for the multiply/divide sequencer and E-stage decode.
// Includes a helper that classifies the long-latency (mult/div) ops.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product and truncating quotient/remainder for the md sequencer.
// Zero latency, no flow control; div_zero flags a div/divu with a zero divisor.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;

    // Division works on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0
    // without relying on signed-overflow behaviour of the divider.
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        neg_a     = is_signed & a[31];
        neg_b     = is_signed & b[31];
        ext_a     = {{32{neg_a}}, a};
        ext_b     = {{32{neg_b}}, b};
        prod      = ext_a * ext_b;
        mag_a     = neg_a ? (~a + 32'd1) : a;
        mag_b     = neg_b ? (~b + 32'd1) : b;
        div_zero  = md_is_div(op) && (b == 32'd0);
        quo       = '0;
        rem       = '0;
        if (b != 32'd0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        if (md_is_div(op)) begin
            res_lo = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
            res_hi = neg_a ? (~rem + 32'd1) : rem;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner beside the E-stage ALU; mult takes MULT_CYCLES, div DIV_CYCLES, mthi/mtlo one edge.
// No backpressure: starts while busy are dropped; md_stall asks the hazard unit to hold D-stage users.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      pend_hi, pend_hi_nxt;
    logic [31:0]      pend_lo, pend_lo_nxt;
    logic             pend_we, pend_we_nxt;
    logic [31:0]      hi_nxt, lo_nxt;
    logic [31:0]      res_hi, res_lo;
    logic             div_zero;

    md_calc u_calc (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_we <= pend_we_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_we_nxt = pend_we;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    if (md_is_long(op)) begin
                        pend_hi_nxt = res_hi;
                        pend_lo_nxt = res_lo;
                        // A zero divisor still burns the full period but leaves HI/LO alone.
                        pend_we_nxt = !div_zero;
                        cnt_nxt     = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_nxt   = RUN;
                    end else if (op == MD_MTHI) begin
                        hi_nxt = a;
                    end else if (op == MD_MTLO) begin
                        lo_nxt = a;
                    end
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    if (pend_we) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == RUN);
    assign md_stall = d_md_use & (busy | (start & md_is_long(op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and randomised bench for md_sequencer with a queue of expected HI/LO results.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        d_md_use = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .d_md_use (d_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference built on longint/int arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] phi,
                                          input logic [31:0] plo);
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        case (o)
            MD_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            MD_MULTU: begin
                up = longint'({32'd0, x}) * longint'({32'd0, y});
                return up;
            end
            MD_DIV: begin
                if (y == 32'd0) return {phi, plo};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {sr, sq};
            end
            default: begin
                if (y == 32'd0) return {phi, plo};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] o, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi     = ehi;
        e.lo     = elo;
        e.cycles = md_is_div(o) ? 32'd10 : 32'd5;
        sb.push_back(e);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic pop_check(input string tag, input int c);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 32'(c), e.cycles);
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
    endtask

    // Issue one long op, then count busy cycles (bounded) and compare HI/LO on completion.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        push_exp(o, ehi, elo);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (busy && c < 40) begin
            c++;
            tick();
        end
        pop_check(tag, c);
    endtask

    initial begin
        logic [63:0] e;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          c;

        reset = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // mthi then mtlo back-to-back
        op = MD_MTHI;
        a = 32'h1234_5678;
        start = 1'b1;
        tick();
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = MD_MTLO;
        a = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // div with a dependent D-stage instruction, plus an illegal start mid-flight
        push_exp(MD_DIV, 32'd2, 32'd14);
        d_md_use = 1'b1;
        op = MD_DIV;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        #1;
        check("stall_start", {31'd0, md_stall}, 32'd1);
        tick();
        start = 1'b0;
        c = 0;
        for (int i = 1; i <= 10; i++) begin
            check("stall_run", {31'd0, md_stall}, 32'd1);
            if (busy) c++;
            if (i == 3) begin
                op = MD_MULT;
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("stall_end", {31'd0, md_stall}, 32'd0);
        check("stall_busy_end", {31'd0, busy}, 32'd0);
        pop_check("div_ignored_start", c);
        d_md_use = 1'b0;

        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        for (int k = 0; k < 6; k++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 1000);
            if (k[0]) ry = $urandom;
            e = model(ro, rx, ry, m_hi, m_lo);
            run_op("rand", ro, rx, ry, e[63:32], e[31:0]);
        end

        // reset two cycles into a mult: no late update afterwards
        op = MD_MTHI;
        a = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        op = MD_MULT;
        a = 32'd6;
        b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_late_busy", {31'd0, busy}, 32'd0);
            check("abort_late_lo", lo, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
